// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester front end.
//   apb_state_e : transfer phase of the requester FSM
//   PPROT_*     : bit positions / common values of the pprot field
//   idx_width() : width of an index into n items (at least 1 bit)
package apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_e;

    localparam int unsigned PPROT_PRIV_BIT      = 0;
    localparam int unsigned PPROT_NONSECURE_BIT = 1;
    localparam int unsigned PPROT_INSTR_BIT     = 2;
    localparam logic [2:0]  PPROT_NORMAL_DATA   = 3'b000;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after ptr, cyclically.
//   req       : request vector
//   ptr       : highest-priority index for this pick (register kept by the parent)
//   grant     : one-hot grant, zero when nothing is requested
//   grant_idx : index of the granted request
//   any_req   : at least one request present
module rr_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned N  = 2,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_req
);

    logic [IW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = IW'((32'(ptr) + i) % N);
            if (!any_req && req[idx]) begin
                any_req    = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/apb_requester_arbiter.sv
// APB requester shared by NUM_REQ local clients. A round-robin pick in IDLE is latched and
// driven through SETUP and ACCESS; the transfer ends on pready or after TIMEOUT_CYCLES ACCESS
// cycles, and a one-cycle response goes back to the granted client.
//   pclk, preset_n                      : clock, async active-low reset
//   req_valid/write/addr/wdata/strb/prot: packed per-requester request fields
//   req_ready                           : one-hot accept (combinational, IDLE only)
//   rsp_valid/rsp_rdata/rsp_err         : one-hot completion pulse with shared data/error
//   psel/penable/paddr/pprot/pwrite/pwdata/pstrb : APB request (registered)
//   pready/prdata/pslverr               : APB completer response (sampled in ACCESS only)
module apb_requester_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned BYTES_PER_WORD = DATA_WIDTH / 8,
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                                pclk,
    input  logic                                preset_n,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wdata,
    input  logic [NUM_REQ*BYTES_PER_WORD-1:0]   req_strb,
    input  logic [NUM_REQ*3-1:0]                req_prot,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]               rsp_rdata,
    output logic                                rsp_err,
    output logic [ADDR_WIDTH-1:0]               paddr,
    output logic [2:0]                          pprot,
    output logic                                pwrite,
    output logic [DATA_WIDTH-1:0]               pwdata,
    output logic [BYTES_PER_WORD-1:0]           pstrb,
    output logic                                psel,
    output logic                                penable,
    input  logic                                pready,
    input  logic [DATA_WIDTH-1:0]               prdata,
    input  logic                                pslverr
);

    localparam int unsigned IW = idx_width(NUM_REQ);
    localparam int unsigned CW = idx_width(TIMEOUT_CYCLES);

    apb_state_e    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gidx_q;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      grant_idx;
    logic               any_req;
    logic               timeout;
    logic               finish;

    logic [ADDR_WIDTH-1:0]     sel_addr;
    logic                      sel_write;
    logic [DATA_WIDTH-1:0]     sel_wdata;
    logic [BYTES_PER_WORD-1:0] sel_strb;
    logic [2:0]                sel_prot;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    assign req_ready = (state_q == APB_IDLE) ? grant : '0;

    // Fields of the granted requester, ready to be latched on accept.
    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_wdata = '0;
        sel_strb  = '0;
        sel_prot  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_write = req_write[i];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_strb  = req_strb[i*BYTES_PER_WORD +: BYTES_PER_WORD];
                sel_prot  = req_prot[i*3 +: 3];
            end
        end
    end

    // Abort on the last allowed ACCESS cycle if the completer still stalls.
    assign timeout = (state_q == APB_ACCESS) && !pready && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign finish  = (state_q == APB_ACCESS) && (pready || timeout);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = '0;
        unique case (state_q)
            APB_IDLE:   if (any_req) state_d = APB_SETUP;
            APB_SETUP:  state_d = APB_ACCESS;
            APB_ACCESS: begin
                if (finish) begin
                    state_d = APB_IDLE;
                    ptr_d   = (32'(gidx_q) == NUM_REQ - 1) ? '0 : gidx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default:    state_d = APB_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q   <= APB_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gidx_q    <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            paddr     <= '0;
            pprot     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            pstrb     <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            rsp_valid <= '0;
            unique case (state_q)
                APB_IDLE: begin
                    if (any_req) begin
                        gidx_q  <= grant_idx;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        paddr   <= sel_addr;
                        pprot   <= sel_prot;
                        pwrite  <= sel_write;
                        pwdata  <= sel_wdata;
                        pstrb   <= sel_write ? sel_strb : '0;
                    end
                end
                APB_SETUP: penable <= 1'b1;
                APB_ACCESS: begin
                    if (finish) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= NUM_REQ'(1) << gidx_q;
                        rsp_err   <= pready ? pslverr : 1'b1;
                        rsp_rdata <= (pready && !pwrite) ? prdata : '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_requester_arbiter.sv
module tb_apb_requester_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int BW = DW / 8;
    localparam int NR = 2;
    localparam int TO = 16;

    logic              pclk = 1'b0;
    logic              preset_n;
    logic [NR-1:0]     req_valid, req_write, req_ready, rsp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR*BW-1:0]  req_strb;
    logic [NR*3-1:0]   req_prot;
    logic [DW-1:0]     rsp_rdata, pwdata, prdata;
    logic              rsp_err, pwrite, psel, penable, pready, pslverr;
    logic [AW-1:0]     paddr;
    logic [2:0]        pprot;
    logic [BW-1:0]     pstrb;

    apb_requester_arbiter #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .req_prot  (req_prot),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .pprot     (pprot),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .psel      (psel),
        .penable   (penable),
        .pready    (pready),
        .prdata    (prdata),
        .pslverr   (pslverr)
    );

    always #5 pclk = ~pclk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Requester side: pending flag and fields per client.
    logic [NR-1:0] pend;
    logic          f_write [NR];
    logic [AW-1:0] f_addr  [NR];
    logic [DW-1:0] f_wdata [NR];
    logic [BW-1:0] f_strb  [NR];
    logic [2:0]    f_prot  [NR];

    // Transaction-level reference: who owns the bus, when it was accepted, when it answers.
    int            mode;          // 0 contention, 1 random, 2 directed only
    int            cyc;
    int            ptr;
    bit            busy;
    int            start_c, resp_c, lat, cur_g;
    logic          cur_write;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata, rd_val, exp_rdata, last_rdata;
    logic [BW-1:0] cur_strb;
    logic [2:0]    cur_prot;
    logic          err_val, exp_err, last_err;
    int            force_lat;
    bit            force_rd;
    logic [DW-1:0] force_rdata;

    function automatic int first_from(input int p, input logic [NR-1:0] v);
        for (int k = 0; k < NR; k++) if (v[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]            = pend[i];
            req_write[i]            = f_write[i];
            req_addr[i*AW +: AW]    = f_addr[i];
            req_wdata[i*DW +: DW]   = f_wdata[i];
            req_strb[i*BW +: BW]    = f_strb[i];
            req_prot[i*3 +: 3]      = f_prot[i];
        end
    endtask

    task automatic post(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [BW-1:0] s, input logic [2:0] p);
        pend[i] = 1'b1; f_write[i] = w; f_addr[i] = a; f_wdata[i] = d; f_strb[i] = s; f_prot[i] = p;
    endtask

    task automatic post_random(input int i);
        post(i, 1'($urandom), AW'($urandom), $urandom, BW'($urandom), 3'($urandom));
    endtask

    task automatic step();
        int  g;
        bit  in_access;
        int  lat_tab [7];
        lat_tab = '{0, 1, 2, 3, TO - 1, TO, TO + 4};
        @(negedge pclk);
        // Registered outputs for this cycle.
        if (busy == 1'b0 && resp_c == cyc && cyc > 0) begin
            check("rsp_valid", 64'(rsp_valid), 64'(NR'(1) << cur_g));
            check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
            check("rsp_err", 64'(rsp_err), 64'(exp_err));
            last_rdata = exp_rdata;
            last_err   = exp_err;
        end else begin
            check("rsp_valid_idle", 64'(rsp_valid), 64'(0));
            check("rsp_rdata_hold", 64'(rsp_rdata), 64'(last_rdata));
            check("rsp_err_hold", 64'(rsp_err), 64'(last_err));
        end
        in_access = busy && (cyc >= start_c + 2);
        if (busy) begin
            check("psel", 64'(psel), 64'(1));
            check("penable", 64'(penable), 64'(in_access));
            check("paddr", 64'(paddr), 64'(cur_addr));
            check("pwrite", 64'(pwrite), 64'(cur_write));
            check("pwdata", 64'(pwdata), 64'(cur_wdata));
            check("pstrb", 64'(pstrb), 64'(cur_write ? cur_strb : '0));
            check("pprot", 64'(pprot), 64'(cur_prot));
        end else begin
            check("psel_idle", 64'(psel), 64'(0));
            check("penable_idle", 64'(penable), 64'(0));
        end
        // Requester activity.
        for (int i = 0; i < NR; i++) begin
            if (mode == 0 && !pend[i]) post_random(i);
            if (mode == 1) begin
                if (!pend[i] && $urandom_range(0, 9) < 4) post_random(i);
                else if (pend[i] && $urandom_range(0, 19) == 0) pend[i] = 1'b0;
            end
        end
        drive_reqs();
        #1;
        g = busy ? -1 : first_from(ptr, pend);
        check("req_ready", 64'(req_ready), (g >= 0) ? 64'(NR'(1) << g) : 64'(0));
        // Completer drives for the current cycle; anything outside ACCESS must be ignored.
        if (in_access && (cyc - (start_c + 2)) == lat && lat < TO) begin
            pready = 1'b1; prdata = rd_val; pslverr = err_val;
        end else begin
            pready  = in_access ? 1'b0 : 1'($urandom);
            prdata  = $urandom;
            pslverr = 1'($urandom);
        end
        if (g >= 0) begin
            cur_g = g; cur_write = f_write[g]; cur_addr = f_addr[g]; cur_wdata = f_wdata[g];
            cur_strb = f_strb[g]; cur_prot = f_prot[g];
            pend[g] = 1'b0;
            start_c = cyc;
            if (force_lat >= 0) lat = force_lat;
            else if (mode == 0) lat = $urandom_range(0, 2);
            else lat = lat_tab[$urandom_range(0, 6)];
            force_lat = -1;
            rd_val  = force_rd ? force_rdata : $urandom;
            force_rd = 1'b0;
            err_val = (mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (lat < TO) begin
                resp_c    = start_c + 3 + lat;
                exp_err   = err_val;
                exp_rdata = cur_write ? '0 : rd_val;
            end else begin
                resp_c    = start_c + 2 + TO;
                exp_err   = 1'b1;
                exp_rdata = '0;
            end
            busy = 1'b1;
        end
        cyc++;
        if (busy && cyc == resp_c) begin
            busy = 1'b0;
            ptr  = (cur_g + 1) % NR;
        end
    endtask

    initial begin
        preset_n = 1'b0;
        pend = '0;
        for (int i = 0; i < NR; i++) post(i, 1'b0, '0, '0, '0, '0);
        pend = '0;
        drive_reqs();
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        mode = 2; cyc = 0; ptr = 0; busy = 1'b0; resp_c = -1; start_c = 0; lat = 0; cur_g = 0;
        last_rdata = '0; last_err = 1'b0; force_lat = -1; force_rd = 1'b0; force_rdata = '0;

        repeat (3) @(posedge pclk);
        #1;
        check("rst_psel", 64'(psel), 64'(0));
        check("rst_penable", 64'(penable), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        check("rst_paddr", 64'(paddr), 64'(0));
        check("rst_pstrb", 64'(pstrb), 64'(0));
        @(negedge pclk);
        preset_n = 1'b1;
        cyc = 1;

        // Single read, pready on the 2nd ACCESS cycle.
        force_lat = 1; force_rd = 1'b1; force_rdata = 32'hDEADBEEF;
        post(0, 1'b0, 10'h010, 32'h0, 4'hF, 3'b000);
        repeat (6) step();
        // Write from requester 1, pready in the 1st ACCESS cycle.
        force_lat = 0;
        post(1, 1'b1, 10'h3FC, 32'h12345678, 4'b0011, 3'b010);
        repeat (5) step();

        // Contention, then fully random traffic with errors and timeouts.
        mode = 0;
        repeat (40) step();
        mode = 1;
        repeat (800) step();
        mode = 2;
        pend = '0;
        for (int n = 0; n < 40 && busy; n++) step();
        check("drain", 64'(busy), 64'(0));
        repeat (2) step();

        // Move the pointer to 1, then reset while requester 1 is stalled in ACCESS.
        force_lat = 0;
        post(0, 1'b0, 10'h020, '0, '0, '0);
        repeat (5) step();
        force_lat = TO + 4;
        post(1, 1'b0, 10'h040, '0, '0, '0);
        repeat (5) step();
        check("pre_rst_psel", 64'(psel), 64'(1));
        check("pre_rst_penable", 64'(penable), 64'(1));
        #2;
        preset_n = 1'b0;
        pend = '0;
        drive_reqs();
        #1;
        check("async_psel", 64'(psel), 64'(0));
        check("async_penable", 64'(penable), 64'(0));
        check("async_rsp_valid", 64'(rsp_valid), 64'(0));
        @(posedge pclk);
        #1;
        check("rst_hold_rsp_valid", 64'(rsp_valid), 64'(0));
        @(negedge pclk);
        preset_n = 1'b1;
        busy = 1'b0; ptr = 0; resp_c = -1; last_rdata = '0; last_err = 1'b0;
        post(0, 1'b1, 10'h100, 32'hA5A5A5A5, 4'hF, 3'b001);
        post(1, 1'b0, 10'h104, '0, '0, '0);
        repeat (14) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
